// File: rtl/shift_iter.sv
// Multi-cycle iterative shifter (LSR/ROL/ASR/ROR), up to STEP bits per clock.
// Shares the start/busy/done stall handshake used by the multiplier and divider.
module shift_iter #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] value,
  input  logic [4:0]  shcnt,
  output logic        busy,
  output logic        done,
  output logic [31:0] res
);

  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
    $error("shift_iter: STEP must be 1, 2, 4, 8 or 16");
  end

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  localparam logic [1:0] OP_LSR = 2'b00;
  localparam logic [1:0] OP_ROL = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [1:0]  op_r, op_n;
  logic [31:0] res_n;
  logic        done_n;
  logic [4:0]  amt;

  // One partial shift of a in 0..STEP. For a=0 the wrap term shifts by 32 and vanishes.
  function automatic logic [31:0] shift_one(input logic [1:0] o, input logic [31:0] v,
                                            input logic [4:0] a);
    logic signed [31:0] sv;
    logic [5:0]         ra;
    ra = 6'd32 - {1'b0, a};
    sv = v;
    case (o)
      OP_LSR:  shift_one = v >> a;
      OP_ROL:  shift_one = (v << a) | (v >> ra);
      OP_ASR:  shift_one = sv >>> a;
      default: shift_one = (v >> a) | (v << ra);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      op_r  <= OP_LSR;
      res   <= 32'd0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_r  <= op_n;
      res   <= res_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_r;
    res_n   = res;
    done_n  = 1'b0;
    amt     = 5'd0;
    case (state)
      IDLE: begin
        if (start) begin
          res_n   = value;
          cnt_n   = shcnt;
          op_n    = op;
          state_n = RUN;
        end
      end
      default: begin
        amt   = (cnt < STEP_AMT) ? cnt : STEP_AMT;
        res_n = shift_one(op_r, res, amt);
        cnt_n = cnt - amt;
        // A zero count still takes exactly one step, which returns the operand unchanged.
        if (cnt_n == 5'd0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    endcase
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_shift_iter.sv
// Self-checking bench for shift_iter (STEP=4): directed cases, reset abort and a
// full op x count sweep against an arithmetic reference model.
module tb_shift_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] value;
  logic [4:0]  shcnt;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  shift_iter #(.STEP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .value(value),
    .shcnt(shcnt), .busy(busy), .done(done), .res(res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Whole-word shift of the full count at once, built from a doubled or extended word.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v, input int n);
    logic [63:0] t;
    case (o)
      2'b00: ref_shift = v >> n;
      2'b01: begin t = {v, v}; t = t >> (32 - n); ref_shift = t[31:0]; end
      2'b10: begin t = {{32{v[31]}}, v}; t = t >> n; ref_shift = t[31:0]; end
      default: begin t = {v, v}; t = t >> n; ref_shift = t[31:0]; end
    endcase
  endfunction

  function automatic int ref_lat(input int n);
    ref_lat = (n == 0) ? 1 : (n + 3) / 4;
  endfunction

  // Entered and left at a falling edge; the return point is the done cycle, so a
  // following call issues its start back-to-back in that cycle.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] v,
                       input int n, input bit noise);
    int cyc;
    logic [31:0] exp;
    exp   = ref_shift(o, v, n);
    start = 1'b1; op = o; value = v; shcnt = 5'(n);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin
      check({tag, " done_while_busy"}, 32'(done), 32'd0);
      if (noise) begin
        start = 1'b1; op = 2'($urandom); value = $urandom; shcnt = 5'($urandom);
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " busy_cycles"}, 32'(cyc), 32'(ref_lat(n)));
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " res"}, res, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; value = 32'd0; shcnt = 5'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset res", res, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("lsr31", 2'b00, 32'h8000_0001, 31, 1'b0);
    check("lsr31 value", res, 32'h0000_0001);
    @(negedge clk);
    check("done_clears", 32'(done), 32'd0);
    check("res_stable", res, 32'h0000_0001);

    do_op("rol1", 2'b01, 32'h8000_0001, 1, 1'b0);
    check("rol1 value", res, 32'h0000_0003);
    do_op("asr4", 2'b10, 32'h8000_0000, 4, 1'b0);
    check("asr4 value", res, 32'hF800_0000);
    do_op("ror8", 2'b11, 32'h1234_5678, 8, 1'b0);
    check("ror8 value", res, 32'h7812_3456);
    for (int o = 0; o < 4; o++) begin
      do_op("zero", 2'(o), 32'hDEAD_BEEF, 0, 1'b0);
      check("zero value", res, 32'hDEAD_BEEF);
    end

    do_op("noise", 2'b11, 32'hA5A5_0F0F, 13, 1'b1);
    do_op("b2b", 2'b00, 32'hFFFF_FFFF, 16, 1'b0);
    check("b2b value", res, 32'h0000_FFFF);
    @(negedge clk);

    // Reset in the third busy cycle of LSR by 31.
    start = 1'b1; op = 2'b00; value = 32'hFFFF_FFFF; shcnt = 5'd31;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_abort busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort res", res, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort no_done", 32'(done), 32'd0);
    end
    do_op("asr31", 2'b10, 32'h8000_0000, 31, 1'b0);
    check("asr31 value", res, 32'hFFFF_FFFF);

    for (int o = 0; o < 4; o++) begin
      for (int n = 0; n < 32; n++) begin
        do_op("sweep", 2'(o), $urandom, n, 1'b0);
      end
    end
    @(negedge clk);
    check("idle after sweep", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
